// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
// Accepts one instruction per IDLE cycle. ALU-only ops and misaligned word
// accesses complete in one cycle. Loads/stores issue a single req/ack data
// memory access and hold the stage (mem_stall) until ack or watchdog abort.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_*                instruction from execute (held by upstream while mem_stall)
//   mem_stall           upstream hold
//   dmem_*              data memory request (req/we/addr/wdata/be out, ack/rdata in)
//   wb_*                registered result strobe to writeback
//   misalign_err        one-cycle pulse, misaligned word access dropped
//   bus_err             one-cycle pulse, access aborted by watchdog
module mem_stage #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_out,
  input  logic [31:0]      ex_store_data,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_byte,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             byte_q, regwr_q;
  logic [REG_W-1:0] rd_q;
  logic             wb_valid_q, wb_regwr_q, mis_q, berr_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [31:0]      wb_data_q;

  logic             ex_mem;
  logic             ex_misaligned;
  logic [31:0]      lane_shift;
  logic [31:0]      load_data;

  assign ex_mem        = ex_mem_read | ex_mem_write;
  assign ex_misaligned = ex_mem & ~ex_byte & (ex_alu_out[1:0] != 2'b00);

  // addr_q is the captured address; it is only nonzero while the request is up,
  // which is exactly when the ack/byte-lane selection needs it.
  always_comb begin
    lane_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
    load_data  = byte_q ? {24'h0, lane_shift[7:0]} : dmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      byte_q     <= 1'b0;
      regwr_q    <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!ex_mem) begin
              wb_valid_q <= 1'b1;
              wb_regwr_q <= ex_reg_write;
              wb_rd_q    <= ex_rd;
              wb_data_q  <= ex_alu_out;
            end else if (ex_misaligned) begin
              wb_valid_q <= 1'b1;
              wb_regwr_q <= 1'b0;
              wb_rd_q    <= ex_rd;
              wb_data_q  <= ex_alu_out;
              mis_q      <= 1'b1;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              // read+write together behaves as a store
              we_q    <= ex_mem_write;
              addr_q  <= ex_alu_out;
              be_q    <= ex_byte ? (4'b0001 << ex_alu_out[1:0]) : 4'hF;
              wdata_q <= ex_byte ? {4{ex_store_data[7:0]}} : ex_store_data;
              byte_q  <= ex_byte;
              regwr_q <= ex_reg_write & ~ex_mem_write;
              rd_q    <= ex_rd;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack || cnt_q == CNT_MAX) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            if (dmem_ack) begin
              wb_regwr_q <= we_q ? 1'b0 : regwr_q;
              wb_data_q  <= we_q ? addr_q : load_data;
            end else begin
              wb_regwr_q <= 1'b0;
              berr_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall    = (state_q == ACCESS);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_regwr_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_byte;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [3:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    bit          mis;
    bit          berr;
  } exp_t;
  exp_t sb[$];

  mem_stage #(.REG_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_byte(ex_byte),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got wb_valid=1 expected no result at %0t", $time);
      end else begin
        automatic exp_t e = sb.pop_front();
        chk("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
        chk("wb_rd", {28'h0, wb_rd}, {28'h0, e.rd});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
        chk("bus_err", {31'h0, bus_err}, {31'h0, e.berr});
      end
    end else if (rst_n && (misalign_err || bus_err)) begin
      checks++;
      errors++;
      $display("FAIL stray_err_pulse: got mis=%0b berr=%0b expected 0 at %0t",
               misalign_err, bus_err, $time);
    end
  end

  function automatic exp_t mk(input logic rw, input logic [3:0] rd, input logic [31:0] data,
                              input bit cd, input bit mis, input bit berr);
    exp_t e;
    e.rw = rw; e.rd = rd; e.data = data; e.chk_data = cd; e.mis = mis; e.berr = berr;
    return e;
  endfunction

  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic by);
    @(negedge clk);
    ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_byte = by;
    ex_valid = 1'b1;
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  // Holds the request for n cycles, acking in the n-th, checking the encoding.
  task automatic serve(input int n, input logic [31:0] rdata, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic we);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("dmem_req_held", {31'h0, dmem_req}, 32'h1);
      chk("mem_stall_held", {31'h0, mem_stall}, 32'h1);
      if (k == 1) begin
        chk("dmem_addr", dmem_addr, addr);
        chk("dmem_be", {28'h0, dmem_be}, {28'h0, be});
        chk("dmem_we", {31'h0, dmem_we}, {31'h0, we});
        if (we) chk("dmem_wdata", dmem_wdata, wdata);
      end
      if (k == n) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      @(posedge clk);
      #1 dmem_ack = 1'b0;
    end
    @(negedge clk);
    chk("dmem_req_done", {31'h0, dmem_req}, 32'h0);
    chk("mem_stall_done", {31'h0, mem_stall}, 32'h0);
    chk("dmem_be_done", {28'h0, dmem_be}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_byte = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
    rst_n = 1'b1;

    // ALU passthrough
    sb.push_back(mk(1'b1, 4'd3, 32'h1234_5678, 1, 0, 0));
    issue(32'h1234_5678, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_no_stall", {31'h0, mem_stall}, 32'h0);
    chk("alu_no_req", {31'h0, dmem_req}, 32'h0);

    // idle cycle: strobe drops, data holds
    @(negedge clk);
    chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("idle_wb_data_hold", wb_data, 32'h1234_5678);

    // word load, ack in 3rd cycle
    sb.push_back(mk(1'b1, 4'd5, 32'hDEAD_BEEF, 1, 0, 0));
    issue(32'h100, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(3, 32'hDEAD_BEEF, 32'h100, 32'h0, 4'hF, 1'b0);

    // byte store to lane 3 (reg_write requested but must be suppressed)
    sb.push_back(mk(1'b0, 4'd7, 32'h203, 1, 0, 0));
    issue(32'h203, 32'hAABB_CC5A, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    serve(2, 32'h0, 32'h203, 32'h5A5A_5A5A, 4'b1000, 1'b1);

    // byte load from lane 2
    sb.push_back(mk(1'b1, 4'd9, 32'h0000_0022, 1, 0, 0));
    issue(32'h202, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    serve(1, 32'h1122_3344, 32'h202, 32'h0, 4'b0100, 1'b0);

    // read+write together is a store
    sb.push_back(mk(1'b0, 4'd2, 32'h0000_0040, 1, 0, 0));
    issue(32'h40, 32'hCAFE_F00D, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    serve(1, 32'hFFFF_FFFF, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1);

    // misaligned word load: dropped
    sb.push_back(mk(1'b0, 4'd4, 32'h0, 0, 1, 0));
    issue(32'h102, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_no_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_no_stall", {31'h0, mem_stall}, 32'h0);

    // watchdog abort: request held 16 cycles
    sb.push_back(mk(1'b0, 4'd6, 32'h0, 0, 0, 1));
    issue(32'h300, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_req) cnt++;
      else break;
    end
    chk("timeout_req_cycles", cnt, 32'd16);
    chk("timeout_back_idle", {31'h0, mem_stall}, 32'h0);

    // ack on the last watchdog cycle wins
    sb.push_back(mk(1'b1, 4'd8, 32'h0BAD_F00D, 1, 0, 0));
    issue(32'h304, 32'h0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(16, 32'h0BAD_F00D, 32'h304, 32'h0, 4'hF, 1'b0);

    // reset mid-access
    issue(32'h400, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", {31'h0, dmem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_mid_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_mid_wb_data", wb_data, 32'h0);
    chk("rst_mid_wb_rd", {28'h0, wb_rd}, 32'h0);
    chk("rst_mid_wb_rw", {31'h0, wb_reg_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(1'b1, 4'd12, 32'h5555_AAAA, 1, 0, 0));
    issue(32'h5555_AAAA, 32'h0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_no_stall", {31'h0, mem_stall}, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
